// File: rtl/assoc_cache_controller.sv
// Two-way set-associative write-back, write-allocate cache controller with
// one-word lines, per-set LRU replacement and saturating hit/miss counters.
module assoc_cache_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;

  // CPU handshake: a request transfers on a rising edge where cpu_req and
  // cpu_ready are both high; cpu_ready is high only while idle, nothing queues.
  // Memory handshake: mem_req and its address/data hold steady until the edge
  // that samples mem_ack high.
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

  state_t              state_q, state_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                hit_q, hit_d;
  logic                way_q, way_d;

  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     valid_d [WAYS];
  logic [SETS-1:0]     dirty_q [WAYS];
  logic [SETS-1:0]     dirty_d [WAYS];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [TAG_W-1:0]    tag_q  [WAYS][SETS];
  logic [TAG_W-1:0]    tag_d  [WAYS][SETS];
  logic [DATA_W-1:0]   data_q [WAYS][SETS];
  logic [DATA_W-1:0]   data_d [WAYS][SETS];

  logic                resp_valid_q, resp_valid_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]    cur_idx, req_idx;
  logic [TAG_W-1:0]    cur_tag, req_tag;
  logic                hit_w0, hit_w1, victim_way;

  assign cur_idx = cpu_addr[IDX_W-1:0];
  assign cur_tag = cpu_addr[ADDR_W-1:IDX_W];
  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

  assign hit_w0 = valid_q[1'b0][cur_idx] && (tag_q[1'b0][cur_idx] == cur_tag);
  assign hit_w1 = valid_q[1'b1][cur_idx] && (tag_q[1'b1][cur_idx] == cur_tag);

  // Invalid ways fill lowest-first; only a full set consults the LRU bit.
  always_comb begin
    if (!valid_q[1'b0][cur_idx])      victim_way = 1'b0;
    else if (!valid_q[1'b1][cur_idx]) victim_way = 1'b1;
    else                              victim_way = lru_q[cur_idx];
  end

  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    hit_d        = hit_q;
    way_d        = way_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    cpu_hit_d    = cpu_hit_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          hit_d       = hit_w0 || hit_w1;
          if (hit_w0 || hit_w1) begin
            way_d   = hit_w1 && !hit_w0;
            state_d = RESPOND;
          end else begin
            way_d     = victim_way;
            mem_req_d = 1'b1;
            if (valid_q[victim_way][cur_idx] && dirty_q[victim_way][cur_idx]) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_q[victim_way][cur_idx], cur_idx};
              mem_wdata_d = data_q[victim_way][cur_idx];
              state_d     = WRITEBACK;
            end else begin
              mem_we_d   = 1'b0;
              mem_addr_d = cpu_addr;
              state_d    = REFILL;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr_q;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          data_d[way_q][req_idx]  = mem_rdata;
          tag_d[way_q][req_idx]   = req_tag;
          valid_d[way_q][req_idx] = 1'b1;
          dirty_d[way_q][req_idx] = 1'b0;
          mem_req_d               = 1'b0;
          mem_we_d                = 1'b0;
          state_d                 = RESPOND;
        end
      end
      RESPOND: begin
        resp_valid_d = 1'b1;
        cpu_hit_d    = hit_q;
        if (req_we_q) begin
          data_d[way_q][req_idx]  = req_wdata_q;
          dirty_d[way_q][req_idx] = 1'b1;
          rdata_d                 = req_wdata_q;
        end else begin
          rdata_d = data_q[way_q][req_idx];
        end
        lru_d[req_idx] = ~way_q;
        if (hit_q) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      hit_q        <= 1'b0;
      way_q        <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      cpu_hit_q    <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      hit_q        <= hit_d;
      way_q        <= way_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      cpu_hit_q    <= cpu_hit_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign cpu_ready      = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_hit        = cpu_hit_q;
  assign cpu_rdata      = rdata_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Randomized scoreboard bench for assoc_cache_controller: a recency-list cache
// model plus a flat golden memory predict hits, read data and memory traffic.
module tb_assoc_cache_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ready, cpu_resp_valid, cpu_hit;
  logic [7:0] cpu_rdata;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0] state_dbg;

  assoc_cache_controller #(.ADDR_W(8), .DATA_W(8), .SETS(4), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0]  exp_q[$];      // {hit, rdata}
  int          acc_q[$];      // acceptance cycle per request
  logic [16:0] mem_exp_q[$];  // {we, addr, wdata}

  // Reference model: per set, a recency list of up to two resident addresses
  // (slot 0 = least recent) and a flat golden memory of current values.
  logic [7:0] bmem   [256];
  logic [7:0] golden [256];
  logic [7:0] m_addr [4][2];
  logic       m_dirty[4][2];
  int         m_cnt  [4];
  int         exp_hits = 0, exp_misses = 0;
  int         mem_delay_force = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_cnt[s] = 0;
    golden = bmem;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int s, hi;
    logic [7:0] rd, ta;
    logic td;
    s  = int'(addr[1:0]);
    hi = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_addr[s][i] == addr) hi = i;
    if (hi >= 0) begin
      if (m_cnt[s] == 2 && hi == 0) begin
        ta = m_addr[s][0]; td = m_dirty[s][0];
        m_addr[s][0] = m_addr[s][1]; m_dirty[s][0] = m_dirty[s][1];
        m_addr[s][1] = ta; m_dirty[s][1] = td;
        hi = 1;
      end
      if (we) m_dirty[s][hi] = 1'b1;
      if (exp_hits < 65535) exp_hits++;
    end else begin
      if (m_cnt[s] == 2) begin
        if (m_dirty[s][0]) mem_exp_q.push_back({1'b1, m_addr[s][0], golden[m_addr[s][0]]});
        m_addr[s][0] = m_addr[s][1]; m_dirty[s][0] = m_dirty[s][1];
        m_cnt[s] = 1;
      end
      mem_exp_q.push_back({1'b0, addr, 8'h00});
      m_addr[s][m_cnt[s]]  = addr;
      m_dirty[s][m_cnt[s]] = we;
      m_cnt[s]++;
      if (exp_misses < 65535) exp_misses++;
    end
    rd = we ? wdata : golden[addr];
    if (we) golden[addr] = wdata;
    exp_q.push_back({hi >= 0, rd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int t = 0;
    @(negedge clk);
    while (!cpu_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("ready_timeout", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    model_access(we, addr, wdata);
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    cpu_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !cpu_ready) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counters();
    check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    check("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
  endtask

  task automatic do_reset(input logic check_now);
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    if (check_now) begin
      check("rst_mem_req_now", 32'(mem_req), 32'd0);
      check("rst_resp_now", 32'(cpu_resp_valid), 32'd0);
    end
    exp_q.delete(); acc_q.delete(); mem_exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_outs", {cpu_resp_valid, cpu_hit, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata}, 32'd0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst && cpu_resp_valid) begin
      logic [8:0] e;
      int a;
      if (exp_q.size() == 0) check("resp_unexpected", 32'(cpu_resp_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_hit", 32'(cpu_hit), 32'(e[8]));
        check("resp_rdata", 32'(cpu_rdata), 32'(e[7:0]));
        if (e[8]) check("hit_latency", 32'(cyc - a + 1), 32'd2);
      end
    end
  end

  // ---------------- memory responder ----------------
  logic       mb_busy = 1'b0, mb_we;
  logic [7:0] mb_addr, mb_wdata;
  int         mb_wait;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst || !mem_req) mb_busy = 1'b0;
    else begin
      if (!mb_busy) begin
        logic [16:0] e;
        mb_busy = 1'b1;
        mb_we = mem_we; mb_addr = mem_addr; mb_wdata = mem_wdata;
        mb_wait = (mem_delay_force >= 0) ? mem_delay_force : int'($urandom_range(0, 3));
        if (mem_exp_q.size() == 0) check("mem_unexpected", 32'(mem_req), 32'd0);
        else begin
          e = mem_exp_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e[16]));
          check("mem_addr", 32'(mem_addr), 32'(e[15:8]));
          if (e[16]) check("mem_wdata", 32'(mem_wdata), 32'(e[7:0]));
        end
      end else begin
        check("mem_stable", {mem_we, mem_addr, mem_wdata}, {mb_we, mb_addr, mb_wdata});
      end
      if (mb_wait == 0) begin
        mem_ack = 1'b1;
        if (mb_we) bmem[mb_addr] = mb_wdata;
        else mem_rdata = bmem[mb_addr];
        mb_busy = 1'b0;
      end else mb_wait--;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
    bmem[8'h14] = 8'hA5;
    do_reset(1'b0);

    // Cold read miss then re-read hit.
    issue(1'b0, 8'h14, 8'h00);
    drain();
    check_counters();
    check("cold_miss_cnt", 32'(miss_cnt), 32'd1);
    issue(1'b0, 8'h14, 8'h00);
    drain();
    check("rehit_hit_cnt", 32'(hit_cnt), 32'd1);

    // Two write misses fill set 0; third miss evicts dirty 0x04.
    issue(1'b1, 8'h04, 8'h11);
    issue(1'b1, 8'h08, 8'h22);
    issue(1'b0, 8'h0C, 8'h00);
    drain();
    check("wb_mem_04", 32'(bmem[8'h04]), 32'h11);
    check_counters();

    // Random traffic over a small address pool to mix hits and evictions.
    for (int n = 0; n < 250; n++)
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
    drain();
    check_counters();

    // Slow memory: requests during the wait must be ignored.
    mem_delay_force = 5;
    issue(1'b1, 8'hF3, 8'h3C);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (cpu_resp_valid) break;
      check("busy_not_ready", 32'(cpu_ready), 32'd0);
      cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
    end
    cpu_req = 1'b0;
    mem_delay_force = -1;
    drain();
    check_counters();

    // Reset in the middle of a refill abandons the request.
    mem_delay_force = 1000;
    issue(1'b0, 8'hE6, 8'h00);
    begin
      int t = 0;
      while (!(mem_req && !mem_we) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check("refill_timeout", 32'(mem_req), 32'd1);
    end
    do_reset(1'b1);
    mem_delay_force = -1;
    repeat (3) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(cpu_resp_valid), 32'd0);
    end
    issue(1'b0, 8'hE6, 8'h00);
    drain();
    check("post_rst_miss", 32'(miss_cnt), 32'd1);

    // Saturation of hit_cnt.
    issue(1'b0, 8'h14, 8'h00);
    drain();
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.hit_cnt_q;
    exp_hits = 65533;
    repeat (3) issue(1'b0, 8'h14, 8'h00);
    drain();
    check("hit_cnt_sat", 32'(hit_cnt), 32'h0000FFFF);
    check_counters();

    repeat (5) @(negedge clk);
    check("leftover_resp", 32'(exp_q.size()), 32'd0);
    check("leftover_mem", 32'(mem_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_cache_controller.md
ASSOC_CACHE_CONTROLLER -- requirements
Module: assoc_cache_controller

Interface
REQ-001 Parameter ADDR_W, default 8, byte address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter SETS, default 4, number of sets; power of two, at least 2.
REQ-004 Parameter WAYS, default 2, associativity; only the value 2 is supported.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high. Ports are as follows.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 cpu_req  in  1  request valid; accepted when cpu_req && cpu_ready.
REQ-009 cpu_we  in  1  1 = write, 0 = read.
REQ-010 cpu_addr  in  ADDR_W  request address.
REQ-011 cpu_wdata  in  DATA_W  write data.
REQ-012 cpu_ready  out  1  high only in state IDLE.
REQ-013 cpu_resp_valid  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  DATA_W  read data; valid with cpu_resp_valid.
REQ-015 cpu_hit  out  1  1 if the completed request hit; valid with cpu_resp_valid.
REQ-016 mem_req  out  1  memory request; held until mem_ack.
REQ-017 mem_we  out  1  1 = write-back, 0 = refill.
REQ-018 mem_addr  out  ADDR_W  memory word address.
REQ-019 mem_wdata  out  DATA_W  write-back data.
REQ-020 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-021 mem_rdata  in  DATA_W  refill data.
REQ-022 hit_cnt  out  16  saturating count of completed hits.
REQ-023 miss_cnt  out  16  saturating count of completed misses.

Function
REQ-024 Address split: index = cpu_addr[log2(SETS)-1:0]; tag = the remaining upper bits. Line size is one word.
REQ-025 Each way SHALL hold valid, dirty, tag and data bits. Each set SHALL hold one LRU bit naming the least-recently-used way.
REQ-026 The FSM SHALL have four states: IDLE, WRITEBACK, REFILL and RESPOND.
REQ-027 IDLE behaviour:
- The request and hit/victim decision are registered on acceptance.
- Hit: go to RESPOND.
- Miss with dirty victim: go to WRITEBACK.
- Miss with clean victim: go to REFILL.
REQ-028 Victim selection on a miss:
- The lowest-numbered invalid way is chosen first.
- If both ways are valid, the LRU way is chosen.
REQ-029 WRITEBACK:
- mem_req=1, mem_we=1.
- mem_addr = {victim tag, index}; mem_wdata = victim data.
- On mem_ack, go to REFILL.
REQ-030 REFILL:
- mem_req=1, mem_we=0, mem_addr = request address.
- On mem_ack: victim data <= mem_rdata, tag updated, valid=1, dirty=0; go to RESPOND.
REQ-031 RESPOND:
- cpu_resp_valid=1 for exactly one cycle; next state is IDLE.
- Read: cpu_rdata = line data.
- Write: line data <= cpu_wdata and dirty=1; cpu_rdata = cpu_wdata.
- The set's LRU bit is set to point at the other way.
REQ-032 cpu_hit SHALL equal the hit decision taken at acceptance. On a hit, cpu_resp_valid asserts exactly 2 cycles after the acceptance edge.
REQ-033 Miss latency SHALL be 2 cycles plus the memory wait cycles (1 or 2 handshakes).
REQ-034 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-035 mem_ack SHALL be ignored outside WRITEBACK and REFILL.
REQ-036 cpu_req SHALL be ignored while cpu_ready=0; no queueing.
REQ-037 hit_cnt and miss_cnt SHALL each increment on a RESPOND cycle and hold at 16'hFFFF.
REQ-038 Write misses SHALL allocate the line (write-allocate), refill it first, then merge the write data.

Reset
REQ-039 rst SHALL force, immediately and asynchronously:
- state to IDLE;
- all valid, dirty and LRU bits to 0;
- cpu_resp_valid, cpu_hit, mem_req and mem_we to 0;
- cpu_rdata, mem_addr and mem_wdata to 0;
- hit_cnt and miss_cnt to 0.
REQ-040 rst asserted mid-transaction SHALL abandon the transaction:
- mem_req drops in the same cycle;
- no response is issued;
- array data contents need not be cleared.

Verification
REQ-041 Cold read: reset, then read 0x14 with mem_rdata=0xA5 -> REFILL, mem_addr=0x14, resp with cpu_hit=0, rdata=0xA5; miss_cnt=1.
REQ-042 Re-read of 0x14 -> resp 2 cycles after accept, cpu_hit=1, rdata=0xA5, no mem_req; hit_cnt=1.
REQ-043 Write 0x04=0x11, write 0x08=0x22, read 0x0C (all index 0):
- mem_we=1, mem_addr=0x04, mem_wdata=0x11;
- then refill 0x0C.
REQ-044 Write with mem_ack delayed 5 cycles -> mem_* stable throughout; cpu_ready=0 and cpu_req ignored.
REQ-045 rst pulsed during REFILL -> mem_req=0 at once, no cpu_resp_valid, and a subsequent read of the same address misses.
REQ-046 Preload hit_cnt to 0xFFFF via hits (or force) -> a further hit leaves it at 0xFFFF.
